snax_dream_stream_engine: RTL
=============================

Name: snax_dream_stream_engine

Overview:
- Compute datapath of the DREAM accelerator; sits between the streamer reader port (stream2acc_0) and the writer port (acc2stream_0).
- Configured through the packed CSR set: 3 RW words in, 2 RO words out.
- Per beat: applies one lane-wise op to 16 signed 32-bit lanes (512-bit beat), selected by CSR.
- Processes a CSR-programmed number of beats per job, then returns to idle and reports status and performance.

Parameters:
- NumRwCsr, 3, number of RW CSR words; fixed, do not change.
- NumRoCsr, 2, number of RO CSR words; fixed, do not change.
- DataWidth, 512, beat width in bits; must equal LaneWidth*16.
- LaneWidth, 32, lane width in bits; lanes are signed two's complement.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stream2acc_0_data_i  in  512  input beat; lane k = bits [32k+31:32k].
- stream2acc_0_valid_i  in  1  input beat valid.
- stream2acc_0_ready_o  out  1  input beat accepted when valid & ready.
- acc2stream_0_data_o  out  512  result beat.
- acc2stream_0_valid_o  out  1  result valid.
- acc2stream_0_ready_i  in  1  writer accepts result.
- csr_reg_set_i  in  3x32  CSR0 = beat count; CSR1 = [1:0] mode, [12:8] shift; CSR2 = signed operand.
- csr_reg_set_valid_i  in  1  job launch request.
- csr_reg_set_ready_o  out  1  launch accepted when valid & ready.
- csr_reg_ro_set_o  out  2x32  RO0 = [0] busy, [31:16] jobs-done count; RO1 = busy-cycle counter of last/current job.

Behaviour:
- Reset: state IDLE; stream2acc_0_ready_o=0; acc2stream_0_valid_o=0; acc2stream_0_data_o=0; csr_reg_set_ready_o=1; all RO bits 0; all internal counters 0. Reset mid-job aborts the job and drops any held result beat.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - csr_reg_set_ready_o=1.
  - On a launch handshake, latch all 3 CSRs into shadow registers; clear in_cnt, out_cnt and RO1.
  - Count==0: stay IDLE, increment the jobs-done count. Otherwise go to RUN.
- RUN:
  - csr_reg_set_ready_o=0; busy=1.
  - stream2acc_0_ready_o = (in_cnt<count) & (!acc2stream_0_valid_o | acc2stream_0_ready_i).
  - Input accept: result registered next cycle (latency 1); in_cnt++.
  - Output handshake: out_cnt++.
  - When in_cnt reaches count, go to DRAIN.
- DRAIN:
  - Input ready=0.
  - When out_cnt==count (last beat handshaken), go to IDLE and increment jobs-done (wraps at 16 bits).
- Output register:
  - Loads on input accept. Accept and output handshake may coincide (full throughput, 1 beat/cycle).
  - acc2stream_0_data_o holds stable while valid & !ready.
- RO1 counts cycles in RUN or DRAIN; saturates at 0xFFFFFFFF; held in IDLE until the next launch.
- Lane ops (shadow mode):
  - 0: pass-through.
  - 1: lane + operand.
  - 2: (lane*operand) >>> shift; 64-bit signed product, arithmetic shift, take low 32 bits.
  - 3: ReLU, i.e. max(lane, 0).
- Without saturation, results wrap modulo 2^32.
- CSR changes while not in IDLE have no effect (shadow registers).

Optional Feature:
- Macro: SNAX_DREAM_SAT_EN.
- Defined: modes 1 and 2 saturate to [-2^31, 2^31-1] instead of wrapping. Adds a 1-bit sticky RO0[1] "saturation occurred" flag, cleared on launch.
- Undefined: wrap arithmetic; RO0[1] reads 0.

Test Plan:
- Launch count=4, mode=1, operand=5; all lanes=10 on 4 back-to-back beats, writer always ready -> 4 beats of lanes=15, one per cycle, first 1 cycle after first accept; then IDLE, RO0=0x00010000.
- Mode=2, operand=3, shift=1, lane=-7 -> lane result -11 (0xFFFFFFF5). Mode=3, lane=-7 -> 0; lane=9 -> 9.
- Writer ready low for 5 cycles in mid-job -> output data held stable; input ready low; no beat lost or duplicated; out_cnt == count at end.
- Launch count=0 -> launch ready, no input ready asserted, jobs-done increments, state stays IDLE.
- Assert rst_i during RUN after 2 of 8 beats -> all outputs at reset values in the same cycle; new launch count=1 works normally.
- SNAX_DREAM_SAT_EN: mode=1, operand=1, lane=0x7FFFFFFF -> 0x7FFFFFFF and RO0[1]=1. Without the macro -> 0x80000000 and RO0[1]=0.

Source files
------------

// File: rtl/snax_dream_stream_engine.sv
// DREAM compute datapath: CSR-launched job applying one lane-wise op to 16x32b signed lanes per beat.
// Optional macro SNAX_DREAM_SAT_EN: saturating add/mul plus sticky saturation flag in RO0[1].

module snax_dream_lane #(
  parameter int W = 32
) (
  input  logic [1:0]   mode_i,
  input  logic [4:0]   shift_i,
  input  logic [W-1:0] op_i,
  input  logic [W-1:0] lane_i,
  output logic [W-1:0] res_o,
  output logic         sat_o
);
  logic [W:0]            sum;
  logic signed [2*W-1:0] prod, shr;
`ifdef SNAX_DREAM_SAT_EN
  logic         sum_ovf, mul_ovf;
  logic [W-1:0] max_v, min_v;
  assign max_v = {1'b0, {(W-1){1'b1}}};
  assign min_v = ~max_v;
`else
  logic unused_hi;
  assign unused_hi = ^{sum[W], shr[2*W-1:W]};
`endif

  always_comb begin
    sum   = {lane_i[W-1], lane_i} + {op_i[W-1], op_i};
    prod  = $signed({{W{lane_i[W-1]}}, lane_i}) * $signed({{W{op_i[W-1]}}, op_i});
    shr   = prod >>> shift_i;
    res_o = lane_i;
    sat_o = 1'b0;
`ifdef SNAX_DREAM_SAT_EN
    sum_ovf = sum[W] ^ sum[W-1];
    // shifted product fits in W bits only if the top W+1 bits are all equal
    mul_ovf = !((&shr[2*W-1:W-1]) | ~(|shr[2*W-1:W-1]));
`endif
    case (mode_i)
      2'd1: begin
        res_o = sum[W-1:0];
`ifdef SNAX_DREAM_SAT_EN
        if (sum_ovf) begin
          res_o = sum[W] ? min_v : max_v;
          sat_o = 1'b1;
        end
`endif
      end
      2'd2: begin
        res_o = shr[W-1:0];
`ifdef SNAX_DREAM_SAT_EN
        if (mul_ovf) begin
          res_o = shr[2*W-1] ? min_v : max_v;
          sat_o = 1'b1;
        end
`endif
      end
      2'd3:    res_o = lane_i[W-1] ? '0 : lane_i;
      default: res_o = lane_i;
    endcase
  end
endmodule

module snax_dream_stream_engine #(
  parameter int NumRwCsr  = 3,
  parameter int NumRoCsr  = 2,
  parameter int DataWidth = 512,
  parameter int LaneWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DataWidth-1:0]          stream2acc_0_data_i,
  input  logic                          stream2acc_0_valid_i,
  output logic                          stream2acc_0_ready_o,
  output logic [DataWidth-1:0]          acc2stream_0_data_o,
  output logic                          acc2stream_0_valid_o,
  input  logic                          acc2stream_0_ready_i,
  input  logic [NumRwCsr-1:0][31:0]     csr_reg_set_i,
  input  logic                          csr_reg_set_valid_i,
  output logic                          csr_reg_set_ready_o,
  output logic [NumRoCsr-1:0][31:0]     csr_reg_ro_set_o
);
  localparam int NumLanes = DataWidth / LaneWidth;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q;
  logic [31:0]            cnt_q, in_cnt_q, out_cnt_q, busy_cyc_q;
  logic [1:0]             mode_q;
  logic [4:0]             shift_q;
  logic [LaneWidth-1:0]   op_q;
  logic [DataWidth-1:0]   out_data_q, res_d;
  logic                   out_valid_q, sat_q;
  logic [15:0]            jobs_q;
  logic [NumLanes-1:0]    lane_sat;
  logic                   in_hs, out_hs, launch, busy;
  logic                   unused_csr;

  assign unused_csr = ^{csr_reg_set_i[1][31:13], csr_reg_set_i[1][7:2]};

  assign busy                 = (state_q != IDLE);
  assign csr_reg_set_ready_o  = (state_q == IDLE);
  assign launch               = csr_reg_set_valid_i & csr_reg_set_ready_o;
  assign stream2acc_0_ready_o = (state_q == RUN) & (in_cnt_q < cnt_q) &
                                (!out_valid_q | acc2stream_0_ready_i);
  assign in_hs                = stream2acc_0_valid_i & stream2acc_0_ready_o;
  assign out_hs               = out_valid_q & acc2stream_0_ready_i;
  assign acc2stream_0_data_o  = out_data_q;
  assign acc2stream_0_valid_o = out_valid_q;
  assign csr_reg_ro_set_o[0]  = {jobs_q, 14'd0, sat_q, busy};
  assign csr_reg_ro_set_o[1]  = busy_cyc_q;

  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    snax_dream_lane #(.W(LaneWidth)) u_lane (
      .mode_i  (mode_q),
      .shift_i (shift_q),
      .op_i    (op_q),
      .lane_i  (stream2acc_0_data_i[k*LaneWidth +: LaneWidth]),
      .res_o   (res_d[k*LaneWidth +: LaneWidth]),
      .sat_o   (lane_sat[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      busy_cyc_q  <= '0;
      mode_q      <= '0;
      shift_q     <= '0;
      op_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      jobs_q      <= '0;
    end else begin
      // output register: a new accept overwrites a beat leaving in the same cycle
      if (in_hs || out_hs) out_valid_q <= in_hs;
      if (in_hs) begin
        out_data_q <= res_d;
        sat_q      <= sat_q | (|lane_sat);
      end
      if (busy && busy_cyc_q != 32'hFFFF_FFFF) busy_cyc_q <= busy_cyc_q + 32'd1;
      case (state_q)
        IDLE: begin
          if (launch) begin
            cnt_q      <= csr_reg_set_i[0];
            mode_q     <= csr_reg_set_i[1][1:0];
            shift_q    <= csr_reg_set_i[1][12:8];
            op_q       <= csr_reg_set_i[2];
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            busy_cyc_q <= '0;
            sat_q      <= 1'b0;
            if (csr_reg_set_i[0] == 32'd0) jobs_q <= jobs_q + 16'd1;
            else                           state_q <= RUN;
          end
        end
        RUN: begin
          if (in_hs) begin
            in_cnt_q <= in_cnt_q + 32'd1;
            if (in_cnt_q + 32'd1 == cnt_q) state_q <= DRAIN;
          end
          if (out_hs) out_cnt_q <= out_cnt_q + 32'd1;
        end
        DRAIN: begin
          if (out_hs) begin
            out_cnt_q <= out_cnt_q + 32'd1;
            if (out_cnt_q + 32'd1 == cnt_q) begin
              state_q <= IDLE;
              jobs_q  <= jobs_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
